// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - generic pipeline stage register with valid/ready, optional skid entry, flush and drop counter
// main entry drives the output; the skid entry catches one input when downstream stalls so in_ready stays registered.

module pipe_stage_buf #(
  parameter int                 DATA_W = 32,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
  parameter int                 SKID   = 1,
  parameter int                 CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [1:0]        occ_q,        occ_d;
  logic [CNT_W-1:0]  drop_cnt_q,   drop_cnt_d;

  logic              acc;
  logic              deq;
  logic [1:0]        drop_inc;
  logic [CNT_W+1:0]  drop_ext;

  assign in_ready  = (SKID != 0) ? !skid_valid_q : (!main_valid_q || out_ready);
  assign acc       = in_valid && in_ready;
  assign deq       = main_valid_q && out_ready;

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_q;
  assign drop_cnt  = drop_cnt_q;

  // An entry leaving downstream in the flush cycle belongs to the consumer, so it is not a drop.
  assign drop_inc = {1'b0, main_valid_q && !out_ready} + {1'b0, skid_valid_q} + {1'b0, acc};
  assign drop_ext = {2'b00, drop_cnt_q} + (CNT_W+2)'(drop_inc);

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    drop_cnt_d   = drop_cnt_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE;
      skid_valid_d = 1'b0;
      skid_data_d  = BUBBLE;
      drop_cnt_d   = (drop_ext > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : drop_ext[CNT_W-1:0];
    end else if (!main_valid_q) begin
      if (acc) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end
    end else if (deq) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (acc && (SKID != 0)) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= BUBBLE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= BUBBLE;
      occ_q        <= 2'd0;
      drop_cnt_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      occ_q        <= occ_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst) skid_valid_q |-> main_valid_q);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed self-checking bench for pipe_stage_buf
// three builds: default, 2-bit drop counter (shares stimulus with default) and SKID=0.

module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [7:0]  drop_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_drop_cnt;

  logic        n_in_valid, n_out_ready, n_in_ready, n_out_valid;
  logic [31:0] n_in_data, n_out_data;
  logic [1:0]  n_occupancy;
  logic [7:0]  n_drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_buf dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  pipe_stage_buf #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .drop_cnt(s_drop_cnt)
  );

  pipe_stage_buf #(.SKID(0)) dut_ns (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occupancy), .drop_cnt(n_drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    n_in_valid = 1'b1; n_in_data = 32'hDEAD_BEEF; n_out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_occ", {30'b0, occupancy}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
    chk("rst_ns_out_valid", {31'b0, n_out_valid}, 32'd0);

    rst = 1'b1; in_valid = 1'b0; n_in_valid = 1'b0;

    // streaming with no bubbles
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i;
      tick();
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_data", out_data, i);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", {31'b0, out_valid}, 32'd0);
    chk("stream_occ", {30'b0, occupancy}, 32'd0);

    // backpressure into skid
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    chk("bp_occ1", {30'b0, occupancy}, 32'd1);
    chk("bp_rdy1", {31'b0, in_ready}, 32'd1);
    in_data = 32'hB;
    tick();
    chk("bp_occ2", {30'b0, occupancy}, 32'd2);
    chk("bp_rdy0", {31'b0, in_ready}, 32'd0);
    chk("bp_head", out_data, 32'hA);
    in_valid = 1'b0;
    tick();
    chk("bp_hold", out_data, 32'hA);
    out_ready = 1'b1;
    tick();
    chk("bp_second", out_data, 32'hB);
    chk("bp_rdy_back", {31'b0, in_ready}, 32'd1);
    chk("bp_occ_after", {30'b0, occupancy}, 32'd1);
    tick();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // single-entry build: combinational ready, same-cycle replace
    n_out_ready = 1'b0; n_in_valid = 1'b1; n_in_data = 32'h5;
    tick();
    chk("ns_out5", n_out_data, 32'h5);
    chk("ns_rdy_held", {31'b0, n_in_ready}, 32'd0);
    n_in_valid = 1'b0;
    tick();
    chk("ns_hold5", n_out_data, 32'h5);
    n_out_ready = 1'b1; n_in_valid = 1'b1; n_in_data = 32'h6;
    #1;
    chk("ns_rdy_comb", {31'b0, n_in_ready}, 32'd1);
    tick();
    chk("ns_out6", n_out_data, 32'h6);
    chk("ns_occ", {30'b0, n_occupancy}, 32'd1);
    n_in_valid = 1'b0;
    tick();
    chk("ns_empty", {31'b0, n_out_valid}, 32'd0);

    // flush with two held entries; in_ready is low so the presented input is not accepted
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC;
    tick();
    in_data = 32'hD;
    tick();
    chk("fl1_occ_pre", {30'b0, occupancy}, 32'd2);
    flush = 1'b1; in_data = 32'hE;
    tick();
    chk("fl1_occ", {30'b0, occupancy}, 32'd0);
    chk("fl1_valid", {31'b0, out_valid}, 32'd0);
    chk("fl1_data", out_data, 32'd0);
    chk("fl1_rdy", {31'b0, in_ready}, 32'd1);
    chk("fl1_drop", {24'b0, drop_cnt}, 32'd2);
    chk("fl1_drop_sat", {30'b0, s_drop_cnt}, 32'd2);

    // one held entry plus an accepted input in the flush cycle
    flush = 1'b0; in_data = 32'hF;
    tick();
    flush = 1'b1; in_data = 32'h10;
    tick();
    chk("fl2_drop", {24'b0, drop_cnt}, 32'd4);
    chk("fl2_drop_sat", {30'b0, s_drop_cnt}, 32'd3);

    // entry dequeued during flush is not a drop
    flush = 1'b0; in_data = 32'h11;
    tick();
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl3_drop", {24'b0, drop_cnt}, 32'd4);
    chk("fl3_valid", {31'b0, out_valid}, 32'd0);

    // saturated counter holds
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h12;
    tick();
    flush = 1'b1; in_data = 32'h13;
    tick();
    chk("fl4_drop", {24'b0, drop_cnt}, 32'd6);
    chk("fl4_drop_sat", {30'b0, s_drop_cnt}, 32'd3);

    // reset beats flush
    flush = 1'b0; in_data = 32'h14;
    tick();
    rst = 1'b0; flush = 1'b1;
    tick();
    chk("rw_drop", {24'b0, drop_cnt}, 32'd0);
    chk("rw_drop_sat", {30'b0, s_drop_cnt}, 32'd0);
    chk("rw_occ", {30'b0, occupancy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
